// File: rtl/vec_max_diff.sv
// Convergence measure: streams two vectors and returns the saturated
// maximum absolute element-wise difference with a one-cycle done pulse.
module vec_max_diff #(
    parameter int N  = 4,
    parameter int W  = 8,
    parameter int AW = 2
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          start_diff,
    output logic          rd_en,
    output logic [AW-1:0] rd_addr,
    input  logic [W-1:0]  v_old_data,
    input  logic [W-1:0]  v_new_data,
    output logic [3:0]    max_d,
    output logic          diff_done,
    output logic          busy
);

    typedef enum logic [1:0] {IDLE, READ, DRAIN, DONE} state_t;

    localparam logic [AW-1:0] LAST = AW'(N - 1);

    state_t        state_q, state_d;
    logic [AW-1:0] cnt_q, cnt_d;
    logic          vld_q, vld_d;
    logic [W-1:0]  run_q, run_d;
    logic [3:0]    max_d_q, max_d_d;

    logic signed [W:0] diff;
    logic [W:0]        diff_abs;
    logic [W-1:0]      mag;
    logic [W-1:0]      run_nxt;

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            vld_q   <= 1'b0;
            run_q   <= '0;
            max_d_q <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            vld_q   <= vld_d;
            run_q   <= run_d;
            max_d_q <= max_d_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE:    if (start_diff) state_d = READ;
            READ:    if (cnt_q == LAST) state_d = DRAIN;
            DRAIN:   state_d = DONE;
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // |new - old| always fits in W unsigned bits once computed at W+1.
    always_comb begin
        diff     = $signed({v_new_data[W-1], v_new_data})
                 - $signed({v_old_data[W-1], v_old_data});
        diff_abs = diff[W] ? (W+1)'(-diff) : (W+1)'(diff);
        mag      = diff_abs[W-1:0];
        run_nxt  = (vld_q && (mag > run_q)) ? mag : run_q;
    end

    always_comb begin
        cnt_d   = cnt_q;
        run_d   = run_nxt;
        vld_d   = rd_en;
        max_d_d = max_d_q;
        if (state_q == IDLE && start_diff) begin
            cnt_d = '0;
            run_d = '0;
        end
        if (state_q == READ && cnt_q != LAST) begin
            cnt_d = cnt_q + 1'b1;
        end
        // The last element is consumed in DRAIN, so fold it in here.
        if (state_q == DRAIN) begin
            max_d_d = (run_nxt > W'(15)) ? 4'd15 : run_nxt[3:0];
        end
    end

    always_comb begin
        rd_en     = (state_q == READ);
        busy      = (state_q != IDLE);
        diff_done = (state_q == DONE);
        rd_addr   = cnt_q;
        max_d     = max_d_q;
    end

endmodule

// File: doc/vec_max_diff.md
Name: vec_max_diff

Overview:
Convergence-measure stage of the power-iteration datapath. On a start pulse from the dominant-eigenvector control FSM, it reads the old and new vectors element by element from the vector register files. It computes the maximum absolute element-wise difference, saturates that value to 4 bits, and returns it on max_d with a single-cycle diff_done pulse. The FSM latches max_d (its max_d_in) in the diff_done cycle and compares it against epsilon.

Parameters:
N, 4, vector length in elements; legal range 2..16.
W, 8, element width; signed two's complement.
AW, 2, read-address width; must equal ceil(log2(N)).

Ports:
clk  in  1  clock; all state updates on rising edge.
reset  in  1  synchronous, active-high reset.
start_diff  in  1  single-cycle start pulse from the control FSM; accepted only in IDLE.
rd_en  out  1  read strobe to both vector register files.
rd_addr  out  AW  element index for the old and new vector reads.
v_old_data  in  W  old-vector element; valid exactly 1 cycle after rd_en for that address.
v_new_data  in  W  new (scaled) vector element; same timing as v_old_data.
max_d  out  4  saturated max |v_new - v_old|; registered; holds until the next completion or reset.
diff_done  out  1  single-cycle completion pulse; max_d is valid in this cycle.
busy  out  1  high in every state except IDLE.

Behaviour:
- Reset (synchronous): state=IDLE, rd_en=0, rd_addr=0, max_d=0, diff_done=0, busy=0; running max=0, address counter=0, read-valid pipe=0.
- Reset while not in IDLE aborts the operation. In the next cycle all outputs are at reset values and no diff_done is issued for the aborted operation.
- States: IDLE, READ, DRAIN, DONE. Encoding is free; the bench observes only ports.
- IDLE: if start_diff=1, clear the running max and the address counter, then go to READ. Otherwise stay in IDLE.
- READ: rd_en=1 and rd_addr=counter. The counter increments each cycle. After issuing address N-1, go to DRAIN.
- DRAIN: rd_en=0 for one cycle while the last element is consumed, then go to DONE.
- DONE: diff_done=1 for exactly one cycle, then go to IDLE.
- Read-valid pipe: rd_en is delayed by 1 cycle. When the delayed strobe is high, the data inputs are consumed in that cycle.
- Arithmetic:
  - Sign-extend both inputs to W+1 bits and compute d = new - old in W+1 bits.
  - |d| fits in W bits unsigned (max 2^W - 1). Take the absolute value with no overflow.
  - running max = max(running max, |d|), unsigned W-bit compare.
- max_d is updated on the edge entering DONE: max_d = (running max > 15) ? 15 : running max[3:0].
- Timing, with cycle c0 = start_diff sampled high in IDLE:
  - c1..cN: rd_en=1, rd_addr=0..N-1.
  - Data for address k is consumed in c(k+2).
  - c(N+1): DRAIN.
  - c(N+2): diff_done=1 and max_d is valid.
  - c(N+3): IDLE.
  - For N=4, diff_done is at c6.
- start_diff while busy=1 (including the DONE cycle) is ignored. It does not restart, extend, or queue an operation.
- start_diff in the first IDLE cycle after DONE is accepted normally. Back-to-back operations are therefore possible every N+3 cycles.
- rd_addr holds its last value when rd_en=0. rd_addr never exceeds N-1 and never wraps mid-operation.
- Input data is ignored in any cycle where the delayed strobe is low.

Test Plan:
1. N=4, old={10,20,30,40}, new={12,17,30,41}, start pulse at c0 → rd_addr 0,1,2,3 on c1..c4; diff_done only at c6; max_d=3.
2. Negative/sign case: old={-5,0,0,0}, new={4,0,0,0} → max_d=9. Then old={0,0,0,-1}, new={0,0,0,-1} → max_d=0.
3. Saturation: old={-128,0,0,0}, new={127,0,0,0} (|d|=255) → max_d=15. Then |d|=16 on one element → max_d=15, and |d|=15 → max_d=15.
4. start_diff re-asserted at c2 and at c6 (DONE) → exactly one diff_done; address sequence 0..3 issued once. A start at c7 (IDLE) gives the next diff_done at c13.
5. Reset asserted at c3 mid-READ → at c4 busy=0, rd_en=0, max_d=0, and no diff_done ever. A fresh start after reset with vectors from test 1 → max_d=3 at the correct latency.
6. max_d retention: after a completion with max_d=7, toggle the data inputs with no start for 20 cycles → max_d stays 7 and diff_done stays 0.
